joy_db15_tx: RTL

JOY_DB15_TX -- requirements
Module: joy_db15_tx

---
 rtl/joy_db15_tx.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/joy_db15_tx.sv
`default_nettype none
// ============================================================================
// Module      : joy_db15_tx
// Description : DB15 adapter responder that emulates a 74HC165 shift chain.
//               It serialises two players' buttons to a host joy_db15 reader.
// Revision    : 1.0 - initial release
// ============================================================================
module joy_db15_tx #(
    parameter int NBITS   = 12,
    parameter int TIMEOUT = 48000
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic [NBITS-1:0]               joy1,
    input  logic [NBITS-1:0]               joy2,
    input  logic                           JOY_CLK,
    input  logic                           JOY_LOAD,
    output logic                           JOY_DATA,
    output logic                           frame_done,
    output logic [$clog2(2*NBITS+1)-1:0]   bit_cnt,
    output logic                           link_active
);

    localparam int c_FRAME_LEN = 2 * NBITS;
    localparam int c_CNT_W     = $clog2(2 * NBITS + 1);
    localparam int c_WD_W      = $clog2(TIMEOUT + 1);

    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(c_FRAME_LEN);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(c_FRAME_LEN - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_WD_W-1:0]  c_WD_MAX   = c_WD_W'(TIMEOUT);
    localparam logic [c_WD_W-1:0]  c_WD_ONE   = c_WD_W'(1);

    // ------------------------------------------------------------------------
    // Host strobe synchronizers and edge detection
    // ------------------------------------------------------------------------
    logic r_clk_s1;
    logic r_clk_s2;
    logic r_clk_prev;
    logic r_load_s1;
    logic r_load_s2;
    logic r_load_prev;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_clk_s1    <= 1'b0;
            r_clk_s2    <= 1'b0;
            r_clk_prev  <= 1'b0;
            r_load_s1   <= 1'b1;
            r_load_s2   <= 1'b1;
            r_load_prev <= 1'b1;
        end else begin
            r_clk_s1    <= JOY_CLK;
            r_clk_s2    <= r_clk_s1;
            r_clk_prev  <= r_clk_s2;
            r_load_s1   <= JOY_LOAD;
            r_load_s2   <= r_load_s1;
            r_load_prev <= r_load_s2;
        end
    end

    // Buttons are delayed by two stages so a button change reaches JOY_DATA
    // with the same latency as a change on the host strobes.
    logic [NBITS-1:0] r_joy1_d1;
    logic [NBITS-1:0] r_joy1_d2;
    logic [NBITS-1:0] r_joy2_d1;
    logic [NBITS-1:0] r_joy2_d2;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_joy1_d1 <= '0;
            r_joy1_d2 <= '0;
            r_joy2_d1 <= '0;
            r_joy2_d2 <= '0;
        end else begin
            r_joy1_d1 <= joy1;
            r_joy1_d2 <= r_joy1_d1;
            r_joy2_d1 <= joy2;
            r_joy2_d2 <= r_joy2_d1;
        end
    end

    logic                   w_load;
    logic                   w_load_fall;
    logic                   w_clk_rise;
    logic                   w_shift;
    logic [c_FRAME_LEN-1:0] w_frame;
    logic                   r_armed;

    assign w_load      = ~r_load_s2;
    assign w_load_fall = r_load_prev & ~r_load_s2;
    assign w_clk_rise  = r_clk_s2 & ~r_clk_prev;
    assign w_shift     = w_clk_rise & r_load_s2 & r_armed;
    assign w_frame     = ~{r_joy2_d2, r_joy1_d2};

    // ------------------------------------------------------------------------
    // Shift chain: r_data is the output stage, r_shift holds frame bits 1..N-1
    // ------------------------------------------------------------------------
    logic [c_FRAME_LEN-2:0] r_shift;
    logic                   r_data;
    logic [c_CNT_W-1:0]     r_bit_cnt;
    logic                   r_frame_done;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_shift      <= '1;
            r_data       <= 1'b1;
            r_bit_cnt    <= '0;
            r_frame_done <= 1'b0;
            r_armed      <= 1'b0;
        end else begin
            r_frame_done <= 1'b0;
            if (w_load) begin
                r_shift   <= w_frame[c_FRAME_LEN-1:1];
                r_data    <= w_frame[0];
                r_bit_cnt <= '0;
                r_armed   <= 1'b1;
            end else if (w_shift) begin
                // Pull-up on the serial input of the last stage
                r_shift <= {1'b1, r_shift[c_FRAME_LEN-2:1]};
                r_data  <= r_shift[0];
                if (r_bit_cnt != c_CNT_MAX) begin
                    r_bit_cnt <= r_bit_cnt + c_CNT_ONE;
                end
                r_frame_done <= (r_bit_cnt == c_CNT_LAST);
            end
        end
    end

    // ------------------------------------------------------------------------
    // Link watchdog, restarted only by a load falling edge
    // ------------------------------------------------------------------------
    logic [c_WD_W-1:0] r_wd_cnt;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_wd_cnt <= c_WD_MAX;
        end else if (w_load_fall) begin
            r_wd_cnt <= '0;
        end else if (r_wd_cnt != c_WD_MAX) begin
            r_wd_cnt <= r_wd_cnt + c_WD_ONE;
        end
    end

    assign JOY_DATA    = r_data;
    assign frame_done  = r_frame_done;
    assign bit_cnt     = r_bit_cnt;
    assign link_active = (r_wd_cnt < c_WD_MAX);

endmodule
`default_nettype wire
